// File: rtl/moore_1010_detector.sv
// moore_1010_detector
// Serial Moore FSM that flags the pattern 1-0-1-0 on input x. The flag y is
// decoded from the state register alone, so it rises on the same edge that
// samples the final 0 and stays high for exactly one cycle.
//
// Build option: define MOORE_1010_OVERLAP_EN for overlapping detection
// (S4 with x=1 resumes at S3). Without it, S4 with x=1 restarts at S1 and a
// complete new "1010" is needed for the next detection.
module moore_1010_detector (
  output logic y,
  input  logic x,
  input  logic clk,
  input  logic reset
);

  typedef enum logic [2:0] {
    S0 = 3'b000,  // idle, no prefix
    S1 = 3'b001,  // seen "1"
    S2 = 3'b010,  // seen "10"
    S3 = 3'b011,  // seen "101"
    S4 = 3'b100   // seen "1010", detect
  } state_t;

  state_t state;
  state_t state_next;

  // State register with asynchronous active-high reset to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its inputs, independent of block order.
      state <= S0;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode from the current state and the sampled bit.
  always_comb begin
    // NOTE: the default assignment first guarantees every path assigns
    // state_next, so no latch is inferred; it also sends illegal encodings
    // (101, 110, 111) back to S0.
    state_next = S0;
    unique case (state)
      S0: state_next = x ? S1 : S0;
      S1: state_next = x ? S1 : S2;
      S2: state_next = x ? S3 : S0;
      S3: state_next = x ? S1 : S4;
`ifdef MOORE_1010_OVERLAP_EN
      // The trailing "10" of a match is reused as the prefix of the next one.
      S4: state_next = x ? S3 : S0;
`else
      // A match consumes all four bits; the trailing 1 only starts a new prefix.
      S4: state_next = x ? S1 : S0;
`endif
      default: state_next = S0;
    endcase
  end

  // Moore output: high only in S4, with no path from x.
  always_comb begin
    y = (state == S4);
  end

endmodule

// File: tb/tb_moore_1010_detector.sv
// tb_moore_1010_detector
// Directed-vector bench for moore_1010_detector. Expected values are written
// by hand from the state diagram; the overlap-dependent vectors follow the
// same MOORE_1010_OVERLAP_EN macro as the design.
module tb_moore_1010_detector;

  logic y;
  logic x;
  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  moore_1010_detector dut (
    .y     (y),
    .x     (x),
    .clk   (clk),
    .reset (reset)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: y=%b expected %b", tag, got, exp);
    end
  endtask

  // Present one bit, clock it in, then sample y 1 unit after the edge.
  task automatic apply(input logic xv, input logic exp_y, input string tag);
    x = xv;
    @(posedge clk);
    #1;
    check(tag, y, exp_y);
  endtask

  initial begin
    // Reset held high across several edges with x=1: y must stay low.
    x     = 1'b1;
    reset = 1'b1;
    #1;
    check("reset_initial", y, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_hold_%0d", i), y, 1'b0);
    end
    reset = 1'b0;

    // Basic match from S0: 0,1,0,1,0 then 0.
    apply(1'b0, 1'b0, "basic_e1");
    apply(1'b1, 1'b0, "basic_e2");
    apply(1'b0, 1'b0, "basic_e3");
    apply(1'b1, 1'b0, "basic_e4");
    apply(1'b0, 1'b1, "basic_e5");
    apply(1'b0, 1'b0, "basic_e6");

    // Back-to-back pattern 1,0,1,0,1,0 then 1,0 from S0.
    apply(1'b1, 1'b0, "seq_e1");
    apply(1'b0, 1'b0, "seq_e2");
    apply(1'b1, 1'b0, "seq_e3");
    apply(1'b0, 1'b1, "seq_e4");
    apply(1'b1, 1'b0, "seq_e5");
`ifdef MOORE_1010_OVERLAP_EN
    apply(1'b0, 1'b1, "seq_e6_overlap");
`else
    apply(1'b0, 1'b0, "seq_e6_no_overlap");
`endif
    apply(1'b1, 1'b0, "seq_e7");
    apply(1'b0, 1'b1, "seq_e8");
    apply(1'b0, 1'b0, "seq_e9");

    // Near misses: S1 self-loop, S2->S0, S3->S1; single pulse at the end.
    apply(1'b1, 1'b0, "near_e1");
    apply(1'b1, 1'b0, "near_e2");
    apply(1'b0, 1'b0, "near_e3");
    apply(1'b0, 1'b0, "near_e4");
    apply(1'b1, 1'b0, "near_e5");
    apply(1'b0, 1'b0, "near_e6");
    apply(1'b1, 1'b0, "near_e7");
    apply(1'b1, 1'b0, "near_e8");
    apply(1'b0, 1'b0, "near_e9");
    apply(1'b1, 1'b0, "near_e10");
    apply(1'b0, 1'b1, "near_e11");
    apply(1'b0, 1'b0, "near_e12");

    // Async reset while in S4: y must drop between edges.
    apply(1'b1, 1'b0, "async4_e1");
    apply(1'b0, 1'b0, "async4_e2");
    apply(1'b1, 1'b0, "async4_e3");
    apply(1'b0, 1'b1, "async4_e4");
    #2;
    reset = 1'b1;
    #1;
    check("async4_mid_cycle", y, 1'b0);
    @(posedge clk);
    #1;
    check("async4_held", y, 1'b0);
    reset = 1'b0;

    // Async reset pulse while in S3, released before the next edge: the
    // partial match is gone, so a following 0 does not detect.
    apply(1'b1, 1'b0, "async3_e1");
    apply(1'b0, 1'b0, "async3_e2");
    apply(1'b1, 1'b0, "async3_e3");
    #2;
    reset = 1'b1;
    #1;
    check("async3_mid_cycle", y, 1'b0);
    reset = 1'b0;
    apply(1'b0, 1'b0, "async3_after");
    // First edge after release samples normally from S0.
    apply(1'b1, 1'b0, "post_e1");
    apply(1'b0, 1'b0, "post_e2");
    apply(1'b1, 1'b0, "post_e3");
    apply(1'b0, 1'b1, "post_e4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
